// File: rtl/pipe_phy_responder.sv
// pipe_phy_responder
//
// Behavioural PHY-side responder for a PIPE bus. Answers the controller's
// receiver-detect requests, PowerDown changes and the post-reset PhyStatus
// handshake with registered PhyStatus/RxStatus and configurable latencies.
//
// Optional feature: define PIPE_PHY_LOOPBACK_EN to loop Tx data/K/valid and
// TxElecIdle back onto the Rx side (one register of delay) while in P0.
// Without the macro the Rx data outputs are tied to 0 and RxElectricalIdle
// to all ones.
//
// Ports:
//   pclk                 PIPE clock (single domain)
//   reset_n              synchronous active-low reset
//   TxDetectRx_Loopback  per-lane receiver-detect request
//   TxElecIdle           per-lane transmitter electrical idle
//   PowerDown            per-lane power state; lane 0 [3:0] is authoritative
//   TxData/TxDataValid/TxDataK  transmit data path (used only for loopback)
//   PhyStatus            per-lane completion/ready status
//   RxStatus             per-lane 3-bit status code
//   RxData/RxDataValid/RxDataK  receive data path
//   RxElectricalIdle     per-lane receiver electrical idle

module pipe_phy_responder #(
    parameter int unsigned MAXPIPEWIDTH = 32,
    parameter int unsigned LANESNUMBER = 16,
    parameter logic [LANESNUMBER-1:0] DETECT_MASK = '1,
    parameter int unsigned RESET_LATENCY = 8,
    parameter int unsigned DETECT_LATENCY = 4,
    parameter int unsigned PWR_LATENCY = 2
) (
    input  logic                                  pclk,
    input  logic                                  reset_n,
    input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
    input  logic [LANESNUMBER-1:0]                TxElecIdle,
    input  logic [4*LANESNUMBER-1:0]              PowerDown,
    input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
    input  logic [LANESNUMBER-1:0]                TxDataValid,
    input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
    output logic [LANESNUMBER-1:0]                PhyStatus,
    output logic [3*LANESNUMBER-1:0]              RxStatus,
    output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
    output logic [LANESNUMBER-1:0]                RxDataValid,
    output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
    output logic [LANESNUMBER-1:0]                RxElectricalIdle
);

    localparam int unsigned DataW = MAXPIPEWIDTH * LANESNUMBER;
    localparam int unsigned KW    = (MAXPIPEWIDTH / 8) * LANESNUMBER;

    // A latency of 0 behaves as 1; the counter is loaded with latency-1.
    localparam int unsigned RstLat = (RESET_LATENCY == 0) ? 1 : RESET_LATENCY;
    localparam int unsigned DetLat = (DETECT_LATENCY == 0) ? 1 : DETECT_LATENCY;
    localparam int unsigned PwrLat = (PWR_LATENCY == 0) ? 1 : PWR_LATENCY;
    localparam logic [7:0] RstLoad = 8'(RstLat - 1);
    localparam logic [7:0] DetLoad = 8'(DetLat - 1);
    localparam logic [7:0] PwrLoad = 8'(PwrLat - 1);

    localparam logic [3:0] PdP0 = 4'd0;
    localparam logic [3:0] PdP1 = 4'd2;

    typedef enum logic [2:0] {
        StRstWait,
        StIdle,
        StDetWait,
        StDetDone,
        StDetHold,
        StPwrWait,
        StPwrDone
    } state_e;

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [3:0]               cur_pd_q, cur_pd_d;
    logic [LANESNUMBER-1:0]   phy_status_q, phy_status_d;
    logic [3*LANESNUMBER-1:0] rx_status_q, rx_status_d;
    logic [3*LANESNUMBER-1:0] det_status;
    logic                     pd_change;
    logic                     det_req;

    // Detect result code per lane: 3'b011 = receiver present.
    always_comb begin
        det_status = '0;
        for (int i = 0; i < int'(LANESNUMBER); i++) begin
            det_status[3*i +: 3] = DETECT_MASK[i] ? 3'b011 : 3'b000;
        end
    end

    assign pd_change = (PowerDown[3:0] != cur_pd_q);
    // Detection is only honoured in P1 with every transmitter electrically idle.
    assign det_req   = (|TxDetectRx_Loopback) && (&TxElecIdle) && (cur_pd_q == PdP1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_pd_d = cur_pd_q;
        unique case (state_q)
            StRstWait: begin
                if (cnt_q == 8'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StIdle: begin
                // Power change wins; a still-held detect request is picked up later.
                if (pd_change) begin
                    cur_pd_d = PowerDown[3:0];
                    cnt_d    = PwrLoad;
                    state_d  = StPwrWait;
                end else if (det_req) begin
                    cnt_d   = DetLoad;
                    state_d = StDetWait;
                end
            end
            StDetWait: begin
                if (cnt_q == 8'd0) state_d = StDetDone;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StDetDone: state_d = StDetHold;
            StDetHold: begin
                // Hold until the request drops so a held request cannot re-trigger.
                if (TxDetectRx_Loopback == '0) state_d = StIdle;
            end
            StPwrWait: begin
                if (cnt_q == 8'd0) state_d = StPwrDone;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StPwrDone: state_d = StIdle;
            default:   state_d = StRstWait;
        endcase
    end

    // Outputs registered from the next state so they line up with it.
    always_comb begin
        phy_status_d = '0;
        rx_status_d  = '0;
        if (state_d == StRstWait || state_d == StDetDone || state_d == StPwrDone) begin
            phy_status_d = '1;
        end
        if (state_d == StDetDone) begin
            rx_status_d = det_status;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q      <= StRstWait;
            cnt_q        <= RstLoad;
            cur_pd_q     <= PdP1;
            phy_status_q <= '1;
            rx_status_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_pd_q     <= cur_pd_d;
            phy_status_q <= phy_status_d;
            rx_status_q  <= rx_status_d;
        end
    end

    assign PhyStatus = phy_status_q;
    assign RxStatus  = rx_status_q;

`ifdef PIPE_PHY_LOOPBACK_EN
    logic [DataW-1:0]       rx_data_q;
    logic [LANESNUMBER-1:0] rx_valid_q;
    logic [KW-1:0]          rx_k_q;
    logic [LANESNUMBER-1:0] rx_eidle_q;

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= '0;
            rx_k_q     <= '0;
            rx_eidle_q <= '1;
        end else if (cur_pd_q == PdP0) begin
            rx_data_q  <= TxData;
            rx_valid_q <= TxDataValid;
            rx_k_q     <= TxDataK;
            rx_eidle_q <= TxElecIdle;
        end else begin
            rx_data_q  <= '0;
            rx_valid_q <= '0;
            rx_k_q     <= '0;
            rx_eidle_q <= '1;
        end
    end

    assign RxData           = rx_data_q;
    assign RxDataValid      = rx_valid_q;
    assign RxDataK          = rx_k_q;
    assign RxElectricalIdle = rx_eidle_q;

    // Only lane 0's PowerDown field is acted on.
    logic unused_pd;
    assign unused_pd = ^PowerDown[4*LANESNUMBER-1:4];
`else
    assign RxData           = '0;
    assign RxDataValid      = '0;
    assign RxDataK          = '0;
    assign RxElectricalIdle = '1;

    // Tx data path is only consumed by the loopback build.
    logic unused_inputs;
    assign unused_inputs = ^{PowerDown[4*LANESNUMBER-1:4], TxData, TxDataValid, TxDataK};
`endif

endmodule

// File: tb/tb_pipe_phy_responder.sv
module tb_pipe_phy_responder;

    localparam int unsigned W   = 32;
    localparam int unsigned L   = 16;
    localparam int unsigned KW  = (W / 8) * L;
    localparam int          RL  = 8;
    localparam int          DL  = 4;
    localparam int          PL  = 2;
    localparam logic [L-1:0] MASK = 16'h000F;

    logic             pclk = 1'b0;
    logic             reset_n = 1'b0;
    logic [L-1:0]     TxDetectRx_Loopback = '0;
    logic [L-1:0]     TxElecIdle = '1;
    logic [4*L-1:0]   PowerDown = {L{4'd2}};
    logic [W*L-1:0]   TxData = '0;
    logic [L-1:0]     TxDataValid = '0;
    logic [KW-1:0]    TxDataK = '0;
    logic [L-1:0]     PhyStatus;
    logic [3*L-1:0]   RxStatus;
    logic [W*L-1:0]   RxData;
    logic [L-1:0]     RxDataValid;
    logic [KW-1:0]    RxDataK;
    logic [L-1:0]     RxElectricalIdle;

    pipe_phy_responder #(
        .MAXPIPEWIDTH  (W),
        .LANESNUMBER   (L),
        .DETECT_MASK   (MASK),
        .RESET_LATENCY (RL),
        .DETECT_LATENCY(DL),
        .PWR_LATENCY   (PL)
    ) dut (
        .pclk               (pclk),
        .reset_n            (reset_n),
        .TxDetectRx_Loopback(TxDetectRx_Loopback),
        .TxElecIdle         (TxElecIdle),
        .PowerDown          (PowerDown),
        .TxData             (TxData),
        .TxDataValid        (TxDataValid),
        .TxDataK            (TxDataK),
        .PhyStatus          (PhyStatus),
        .RxStatus           (RxStatus),
        .RxData             (RxData),
        .RxDataValid        (RxDataValid),
        .RxDataK            (RxDataK),
        .RxElectricalIdle   (RxElectricalIdle)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int             due;
        logic [L-1:0]   phy;
        logic [3*L-1:0] rx;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [3*L-1:0] det_rx;
    bit             seen;
    int             at;
    logic [L-1:0]   phy;
    logic [3*L-1:0] rx;
    bit             quiet;
    int             k;
    int             r;

    // Monitor: waits (bounded) for a nonzero PhyStatus and reports what it saw.
    task automatic wait_pulse(input int budget, output bit s, output int t,
                              output logic [L-1:0] p, output logic [3*L-1:0] x);
        s = 1'b0;
        t = -1;
        p = '0;
        x = '0;
        for (int n = 0; n < budget && !s; n++) begin
            @(negedge pclk);
            if (PhyStatus !== '0) begin
                s = 1'b1;
                t = cyc;
                p = PhyStatus;
                x = RxStatus;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge pclk);
        tests_run++;
        if (PhyStatus !== '1 || RxStatus !== '0 || RxElectricalIdle !== '1) begin
            tests_failed++;
            $display("FAIL reset_values: phy=%h rx=%h eidle=%h, want phy=ffff rx=0 eidle=ffff",
                     PhyStatus, RxStatus, RxElectricalIdle);
        end
        tests_run++;
        if (RxData !== '0 || RxDataValid !== '0 || RxDataK !== '0) begin
            tests_failed++;
            $display("FAIL reset_rxdata: data=%h valid=%h k=%h, want all 0",
                     RxData, RxDataValid, RxDataK);
        end
        reset_n = 1'b1;
        r = cyc;
        for (int i = 1; i <= RL; i++) begin
            @(negedge pclk);
            tests_run++;
            if (PhyStatus !== ((i < RL) ? {L{1'b1}} : {L{1'b0}})) begin
                tests_failed++;
                $display("FAIL reset_phystatus_cycle%0d: phy=%h, want %h", i, PhyStatus,
                         (i < RL) ? {L{1'b1}} : {L{1'b0}});
            end
        end
    endtask

    task automatic test_detect();
        // First request, held.
        k = cyc;
        TxDetectRx_Loopback = '1;
        sb.push_back('{k + 1 + DL, {L{1'b1}}, det_rx});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL detect_pulse: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        @(negedge pclk);
        tests_run++;
        if (PhyStatus !== '0 || RxStatus !== '0) begin
            tests_failed++;
            $display("FAIL detect_width: phy=%h rx=%h, want 0 0", PhyStatus, RxStatus);
        end
        quiet = 1'b1;
        repeat (12) begin
            @(negedge pclk);
            if (PhyStatus !== '0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL detect_held_no_retrigger: pulse seen=1, want 0");
        end
        // Drop, then re-raise: a new result is due.
        TxDetectRx_Loopback = '0;
        @(negedge pclk);
        k = cyc;
        TxDetectRx_Loopback = '1;
        sb.push_back('{k + 1 + DL, {L{1'b1}}, det_rx});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL detect_reraise: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        TxDetectRx_Loopback = '0;
        repeat (2) @(negedge pclk);
        // Not fully electrically idle: request ignored.
        TxElecIdle = 16'hFFFE;
        TxDetectRx_Loopback = '1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge pclk);
            if (PhyStatus !== '0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL detect_not_eidle: pulse seen=1, want 0");
        end
        TxDetectRx_Loopback = '0;
        TxElecIdle = '1;
        @(negedge pclk);
    endtask

    task automatic test_power();
        k = cyc;
        PowerDown[3:0] = 4'd0;
        sb.push_back('{k + 1 + PL, {L{1'b1}}, {3*L{1'b0}}});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL power_p1_to_p0: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        @(negedge pclk);
        tests_run++;
        if (PhyStatus !== '0) begin
            tests_failed++;
            $display("FAIL power_width: phy=%h, want 0", PhyStatus);
        end
        // Detect outside P1 is ignored.
        TxDetectRx_Loopback = '1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge pclk);
            if (PhyStatus !== '0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL detect_in_p0: pulse seen=1, want 0");
        end
        TxDetectRx_Loopback = '0;
        @(negedge pclk);
        k = cyc;
        PowerDown[3:0] = 4'd2;
        sb.push_back('{k + 1 + PL, {L{1'b1}}, {3*L{1'b0}}});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL power_p0_to_p1: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        @(negedge pclk);
    endtask

    task automatic test_collision();
        // Power change to P0 with detect: power pulse only.
        k = cyc;
        PowerDown[3:0] = 4'd0;
        TxDetectRx_Loopback = '1;
        sb.push_back('{k + 1 + PL, {L{1'b1}}, {3*L{1'b0}}});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL collide_to_p0_power: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        quiet = 1'b1;
        repeat (12) begin
            @(negedge pclk);
            if (PhyStatus !== '0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL collide_to_p0_no_detect: pulse seen=1, want 0");
        end
        // Power change to P1 with detect still held: power pulse, then detect result.
        k = cyc;
        PowerDown[3:0] = 4'd2;
        sb.push_back('{k + 1 + PL, {L{1'b1}}, {3*L{1'b0}}});
        sb.push_back('{k + 3 + PL + DL, {L{1'b1}}, det_rx});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL collide_to_p1_power: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL collide_to_p1_detect: seen=%0d at=%0d phy=%h rx=%h, want at=%0d phy=%h rx=%h",
                     seen, at, phy, rx, e.due, e.phy, e.rx);
        end
        TxDetectRx_Loopback = '0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_reset_mid();
        TxDetectRx_Loopback = '1;
        repeat (2) @(negedge pclk);
        reset_n = 1'b0;
        TxDetectRx_Loopback = '0;
        @(negedge pclk);
        tests_run++;
        if (PhyStatus !== '1 || RxStatus !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_detect: phy=%h rx=%h, want phy=ffff rx=0",
                     PhyStatus, RxStatus);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= RL; i++) begin
            @(negedge pclk);
            tests_run++;
            if (PhyStatus !== ((i < RL) ? {L{1'b1}} : {L{1'b0}}) || RxStatus !== '0) begin
                tests_failed++;
                $display("FAIL reset_mid_seq_cycle%0d: phy=%h rx=%h, want phy=%h rx=0", i,
                         PhyStatus, RxStatus, (i < RL) ? {L{1'b1}} : {L{1'b0}});
            end
        end
    endtask

    task automatic test_rx_path();
        k = cyc;
        PowerDown[3:0] = 4'd0;
        sb.push_back('{k + 1 + PL, {L{1'b1}}, {3*L{1'b0}}});
        wait_pulse(40, seen, at, phy, rx);
        e = sb.pop_front();
        tests_run++;
        if (!seen || at != e.due || phy !== e.phy || rx !== e.rx) begin
            tests_failed++;
            $display("FAIL rxpath_enter_p0: seen=%0d at=%0d phy=%h rx=%h, want at=%0d",
                     seen, at, phy, rx, e.due);
        end
        @(negedge pclk);
        for (int i = 0; i < int'(L); i++) TxData[W*i +: W] = $urandom;
        TxData[W-1:0] = 32'hBC1C1C1C;
        TxDataK       = '0;
        TxDataK[3:0]  = 4'hF;
        TxDataValid   = 16'h0001;
        TxElecIdle    = 16'h0000;
        @(negedge pclk);
`ifdef PIPE_PHY_LOOPBACK_EN
        tests_run++;
        if (RxData[W-1:0] !== 32'hBC1C1C1C || RxDataK[3:0] !== 4'hF) begin
            tests_failed++;
            $display("FAIL loopback_lane0: data=%h k=%h, want bc1c1c1c f",
                     RxData[W-1:0], RxDataK[3:0]);
        end
        tests_run++;
        if (RxData !== TxData || RxDataValid !== 16'h0001 || RxElectricalIdle !== 16'h0000) begin
            tests_failed++;
            $display("FAIL loopback_all: valid=%h eidle=%h data_eq=%0d, want 0001 0000 1",
                     RxDataValid, RxElectricalIdle, RxData === TxData);
        end
`else
        tests_run++;
        if (RxData !== '0 || RxDataK !== '0 || RxDataValid !== '0 ||
            RxElectricalIdle !== '1) begin
            tests_failed++;
            $display("FAIL rx_tied_off: data=%h k=%h valid=%h eidle=%h, want 0 0 0 ffff",
                     RxData, RxDataK, RxDataValid, RxElectricalIdle);
        end
`endif
        TxElecIdle = '1;
    endtask

    initial begin
        det_rx = '0;
        for (int i = 0; i < 4; i++) det_rx[3*i +: 3] = 3'b011;
        test_reset();
        test_detect();
        test_power();
        test_collision();
        test_reset_mid();
        test_rx_path();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish before limit");
        $fatal(1);
    end

endmodule
